seq_shift_add_multiplier: RTL and testbench

Parametrised, iterative shift-and-add multiplier. Next generation of the team's fixed 4x4 combinational array multiplier.
Generalised to WIDTH-bit operands, with optional two's-complement mode and a start/busy/done handshake.

---
 rtl/mul_pkg.sv | 19 +
 rtl/seq_shift_add_multiplier.sv | 100 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiply engines and future signed datapath blocks.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Widest operand any engine supports; helpers work at twice that width.
  localparam int MAX_W = 16;
  localparam int PW    = 2 * MAX_W;

  // Two's-complement negate when neg is set. Callers size-cast in and out.
  function automatic logic [PW-1:0] cond_negate(input logic [PW-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier: one partial product per clock, optional
// two's-complement mode, start/busy/done handshake.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  import mul_pkg::*;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       sum;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    acc_d     = acc_q;
    product_d = product_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]};

    case (state_q)
      IDLE: begin
        if (start) begin
          // Magnitudes fit unsigned in WIDTH bits, including the most-negative value.
          mcand_d  = WIDTH'(cond_negate(PW'($signed(a)), signed_mode & a[WIDTH-1]));
          mplier_d = WIDTH'(cond_negate(PW'($signed(b)), signed_mode & b[WIDTH-1]));
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with the state itself.
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
    if (state_q == RUN && state_d == FIN)
      product_d = (2*WIDTH)'(cond_negate(PW'(acc_d), neg_q));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      product_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values regardless of order.
      state_q   <= state_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: 8-bit vectors, handshake/abort/hold sequences and an
// exhaustive 4-bit sweep, with expected products queued at issue time.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, sm8, start4, sm4;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic        busy8, done8, busy4, done4;
  logic [15:0] product8;
  logic [7:0]  product4;

  int checks = 0;
  int errors = 0;

  logic [15:0] q8[$];
  logic [7:0]  q4[$];
  logic        prev_done8 = 1'b0;
  logic        prev_done4 = 1'b0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop an expected product on every done pulse.
  always begin
    @(posedge clk);
    #1;
    if (busy8 && done8) check("busy_done_overlap8", {busy8, done8}, 2'b01);
    if (done8 && prev_done8) check("double_done8", prev_done8 & done8, 1'b0);
    prev_done8 = done8;
    if (done8) begin
      if (q8.size() == 0) check("spurious_done8", done8, 1'b0);
      else check("product8", product8, q8.pop_front());
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (busy4 && done4) check("busy_done_overlap4", {busy4, done4}, 2'b01);
    if (done4 && prev_done4) check("double_done4", prev_done4 & done4, 1'b0);
    prev_done4 = done4;
    if (done4) begin
      if (q4.size() == 0) check("spurious_done4", done4, 1'b0);
      else check("product4", product4, q4.pop_front());
    end
  end

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic sm,
                     input logic [15:0] exp);
    int n;
    a8 = ia; b8 = ib; sm8 = sm; start8 = 1'b1;
    q8.push_back(exp);
    tick();
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check("latency8", n, 9);
    tick();
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic sm,
                     input logic [7:0] exp);
    int n;
    a4 = ia; b4 = ib; sm4 = sm; start4 = 1'b1;
    q4.push_back(exp);
    tick();
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 40) begin
      tick();
      n++;
    end
    check("latency4", n, 5);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] done_mask;
    logic signed [3:0] sa, sb;
    int p;

    vecs[0] = '{8'd200, 8'd250, 1'b0, 16'hC350};
    vecs[1] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1};
    vecs[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[3] = '{8'h80,  8'h7F,  1'b1, 16'hC080};
    vecs[4] = '{8'h00,  8'hF9,  1'b1, 16'h0000};
    vecs[5] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[6] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    vecs[7] = '{8'h07,  8'hF9,  1'b1, 16'hFFCF};
    vecs[8] = '{8'h80,  8'h80,  1'b0, 16'h4000};

    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    tick();
    tick();
    check("reset_busy8", busy8, 1'b0);
    check("reset_done8", done8, 1'b0);
    check("reset_product8", product8, 16'h0000);
    check("reset_product4", product4, 8'h00);
    rst_n = 1'b1;
    tick();

    // Unsigned 200*250 with cycle-by-cycle handshake timing.
    a8 = 8'd200; b8 = 8'd250; sm8 = 1'b0; start8 = 1'b1;
    q8.push_back(16'hC350);
    tick();
    start8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("timing_run_c%0d", c), {busy8, done8}, 2'b10);
      tick();
    end
    check("timing_fin_c9", {busy8, done8}, 2'b01);
    tick();
    check("timing_idle_c10", {busy8, done8}, 2'b00);
    check("hold_after_done", product8, 16'hC350);

    for (int i = 0; i < 9; i++) op8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);

    // Start pulses during RUN (cycle 3) and FIN (cycle 9) are ignored; cycle 10 is accepted.
    done_mask = '0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      if (done8) done_mask[cyc] = 1'b1;
      start8 = (cyc == 0 || cyc == 3 || cyc == 9 || cyc == 10);
      sm8 = 1'b0;
      if (cyc == 0) begin
        a8 = 8'd7; b8 = 8'd9; q8.push_back(16'd63);
      end else if (cyc == 10) begin
        a8 = 8'd12; b8 = 8'd13; q8.push_back(16'd156);
      end else begin
        a8 = 8'hFF; b8 = 8'hFF;
      end
      tick();
    end
    start8 = 1'b0;
    check("handshake_done_cycles", done_mask, (32'd1 << 9) | (32'd1 << 19));

    // Operands wiggle every cycle while busy; result must follow the latched values.
    a8 = 8'hFD; b8 = 8'h05; sm8 = 1'b1; start8 = 1'b1;
    q8.push_back(16'hFFF1);
    tick();
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
      tick();
      n++;
    end
    check("hold_latency8", n, 9);
    tick();
    tick();
    check("hold_product_stable", product8, 16'hFFF1);

    // Reset asserted in cycle 4 aborts the operation with no done pulse.
    a8 = 8'd99; b8 = 8'd99; sm8 = 1'b0; start8 = 1'b1;
    q8.push_back(16'd9801);
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    q8.delete();
    tick();
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_product", product8, 16'h0000);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done8) n++;
    end
    check("abort_no_done", n, 0);

    // Exhaustive 4-bit sweep, unsigned then signed.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op4(4'(i), 4'(j), 1'b0, 8'(i * j));
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        sa = 4'(i);
        sb = 4'(j);
        p = int'(sa) * int'(sb);
        op4(4'(i), 4'(j), 1'b1, p[7:0]);
      end

    tick();
    tick();
    check("scoreboard8_drained", q8.size(), 0);
    check("scoreboard4_drained", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
